// File: rtl/mem_access_ctrl_pkg.sv
// Shared LC-3b types for the memory-stage access controller: data word,
// MEM-stage control word and controller state encoding.
package mem_access_ctrl_pkg;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_indirect;
    logic mem_byte;
  } lc3b_control_word_mem;

  typedef enum logic [1:0] {
    IDLE,
    IND,
    ACCESS
  } lc3b_mem_state;

  localparam logic [1:0] BE_NONE = '0;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = '1;

  function automatic lc3b_word word_align(input lc3b_word addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane steering: write lane mask, replicated store data
// and zero-extended load byte selected by address bit 0.
module mem_byte_lane
  import mem_access_ctrl_pkg::*;
(
  input  logic        addr0_i,
  input  logic        mem_byte_i,
  input  logic [15:0] mdr_i,
  input  logic [15:0] rdata_i,
  output logic [1:0]  byte_enable_o,
  output logic [15:0] wdata_o,
  output logic [15:0] load_data_o
);

  always_comb begin
    byte_enable_o = BE_WORD;
    wdata_o       = mdr_i;
    load_data_o   = rdata_i;
    if (mem_byte_i) begin
      // Byte stores put the byte on both lanes; the mask picks the one written.
      byte_enable_o = addr0_i ? BE_HI : BE_LO;
      wdata_o       = {mdr_i[7:0], mdr_i[7:0]};
      load_data_o   = addr0_i ? {8'h00, rdata_i[15:8]} : {8'h00, rdata_i[7:0]};
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: sequences direct and indirect
// (LDI/STI) accesses, drives the request handshake and stalls the pipeline.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  lc3b_control_word_mem       mem_sig_in,
  input  logic                       init_MEM,
  input  logic [15:0]                mar_MEM,
  input  logic [15:0]                mdr_MEM,
  output logic [15:0]                dmem_address,
  output logic                       dmem_read,
  output logic                       dmem_write,
  output logic [1:0]                 dmem_byte_enable,
  output logic [15:0]                dmem_wdata,
  input  logic [15:0]                dmem_rdata,
  input  logic                       dmem_resp,
  output logic                       mem_stall,
  output logic [15:0]                load_data,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  lc3b_mem_state               state_q, state_d;
  lc3b_word                    pointer_q, pointer_d;
  logic [STALL_CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

  logic     memop;
  lc3b_word target;
  logic [1:0]  lane_be;
  logic [15:0] lane_wdata;
  logic [15:0] lane_load;

  assign memop  = init_MEM & (mem_sig_in.mem_read | mem_sig_in.mem_write);
  assign target = mem_sig_in.mem_indirect ? pointer_q : mar_MEM;

  // Reset gates the stall so it drops immediately, not just at the next edge.
  assign mem_stall = reset_n & memop & ~((state_q == ACCESS) & dmem_resp);

  mem_byte_lane u_lane (
    .addr0_i      (target[0]),
    .mem_byte_i   (mem_sig_in.mem_byte),
    .mdr_i        (mdr_MEM),
    .rdata_i      (dmem_rdata),
    .byte_enable_o(lane_be),
    .wdata_o      (lane_wdata),
    .load_data_o  (lane_load)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pointer_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pointer_q   <= pointer_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pointer_d   = pointer_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (memop) state_d = mem_sig_in.mem_indirect ? IND : ACCESS;
      end
      IND: begin
        if (dmem_resp) begin
          pointer_d = dmem_rdata;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (dmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (mem_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
  end

  always_comb begin
    dmem_address     = '0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_byte_enable = BE_NONE;
    dmem_wdata       = '0;
    load_data        = '0;
    unique case (state_q)
      IND: begin
        dmem_read    = 1'b1;
        dmem_address = word_align(mar_MEM);
      end
      ACCESS: begin
        dmem_address = mem_sig_in.mem_byte ? target : word_align(target);
        // A write takes priority when both read and write are flagged.
        if (mem_sig_in.mem_write) begin
          dmem_write       = 1'b1;
          dmem_byte_enable = lane_be;
          dmem_wdata       = lane_wdata;
        end else begin
          dmem_read = 1'b1;
          load_data = lane_load;
        end
      end
      default: ;
    endcase
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed test-plan scenarios plus
// randomized back-to-back accesses against a transaction-level model.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_n;
  lc3b_control_word_mem mem_sig;
  logic                 init;
  logic [15:0]          mar, mdr, rdata;
  logic                 resp;

  logic [15:0] addr_o, wdata_o, load_o;
  logic        rd_o, wr_o, stall_o;
  logic [1:0]  be_o;
  logic [15:0] cnt_o;

  logic [15:0] addr4, wdata4, load4;
  logic        rd4, wr4, stall4;
  logic [1:0]  be4;
  logic [3:0]  cnt4;

  int tests = 0;
  int fails = 0;
  int total_stall = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .reset_n(reset_n), .mem_sig_in(mem_sig), .init_MEM(init),
    .mar_MEM(mar), .mdr_MEM(mdr), .dmem_address(addr_o), .dmem_read(rd_o),
    .dmem_write(wr_o), .dmem_byte_enable(be_o), .dmem_wdata(wdata_o),
    .dmem_rdata(rdata), .dmem_resp(resp), .mem_stall(stall_o),
    .load_data(load_o), .stall_count(cnt_o)
  );

  mem_access_ctrl #(.STALL_CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .mem_sig_in(mem_sig), .init_MEM(init),
    .mar_MEM(mar), .mdr_MEM(mdr), .dmem_address(addr4), .dmem_read(rd4),
    .dmem_write(wr4), .dmem_byte_enable(be4), .dmem_wdata(wdata4),
    .dmem_rdata(rdata), .dmem_resp(resp), .mem_stall(stall4),
    .load_data(load4), .stall_count(cnt4)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got %0d tests", tests);
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    reset_n = 1'b0;
    init = 1'b0; mem_sig = '0; mar = '0; mdr = '0; rdata = '0; resp = 1'b0;
    #3;
    tests++;
    if ({addr_o, rd_o, wr_o, be_o, wdata_o, stall_o, load_o, cnt_o, cnt4} !== '0)
      begin fails++; $display("FAIL reset_state: got addr=%h rd=%b wr=%b be=%b wd=%h stall=%b ld=%h cnt=%h cnt4=%h want all zero",
        addr_o, rd_o, wr_o, be_o, wdata_o, stall_o, load_o, cnt_o, cnt4); end
    @(posedge clk); #2;
    reset_n = 1'b1;
    total_stall = 0;
  endtask

  // One memory instruction from IDLE to final response; the memory side
  // answers each request after the given number of wait cycles.
  task automatic run_op(input bit rd_f, input bit wr_f, input bit ind_f, input bit byt_f,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] r1, input logic [15:0] r2,
                        input int d1, input int d2, input bit idle_resp);
    logic [15:0] tgt, exp_addr, exp_wd, exp_ld;
    logic [1:0]  exp_be;
    int          s16, s4;
    @(posedge clk); #1;
    s16 = (total_stall > 65535) ? 65535 : total_stall;
    s4  = (total_stall > 15) ? 15 : total_stall;
    tests++;
    if (cnt_o !== 16'(s16)) begin fails++; $display("FAIL stall_count: got %0d want %0d", cnt_o, s16); end
    tests++;
    if (cnt4 !== 4'(s4)) begin fails++; $display("FAIL stall_count_sat4: got %0d want %0d", cnt4, s4); end
    mem_sig = '{mem_read: rd_f, mem_write: wr_f, mem_indirect: ind_f, mem_byte: byt_f};
    init = 1'b1; mar = a; mdr = d; resp = idle_resp; rdata = 16'($urandom);
    #1;
    tests++;
    if ({rd_o, wr_o, stall_o} !== 3'b001)
      begin fails++; $display("FAIL idle_cycle: got rd=%b wr=%b stall=%b want 0 0 1", rd_o, wr_o, stall_o); end
    if (ind_f) begin
      for (int k = 0; k <= d1; k++) begin
        @(posedge clk); #1;
        resp  = (k == d1);
        rdata = resp ? r1 : 16'($urandom);
        #1;
        tests++;
        if ({addr_o, rd_o, wr_o, stall_o, load_o} !== {a & 16'hFFFE, 1'b1, 1'b0, 1'b1, 16'h0000})
          begin fails++; $display("FAIL ptr_fetch: got addr=%h rd=%b wr=%b stall=%b ld=%h want addr=%h rd=1 wr=0 stall=1 ld=0000",
            addr_o, rd_o, wr_o, stall_o, load_o, a & 16'hFFFE); end
      end
    end
    tgt      = ind_f ? r1 : a;
    exp_addr = byt_f ? tgt : (tgt & 16'hFFFE);
    exp_be   = wr_f ? (byt_f ? (tgt[0] ? 2'b10 : 2'b01) : 2'b11) : 2'b00;
    exp_wd   = wr_f ? (byt_f ? {2{d[7:0]}} : d) : 16'h0000;
    exp_ld   = (rd_f && !wr_f) ? (byt_f ? (tgt[0] ? (r2 >> 8) : (r2 & 16'h00FF)) : r2) : 16'h0000;
    for (int k = 0; k <= d2; k++) begin
      @(posedge clk); #1;
      resp  = (k == d2);
      rdata = resp ? r2 : 16'($urandom);
      #1;
      tests++;
      if ({addr_o, rd_o, wr_o, be_o, wdata_o, stall_o} !== {exp_addr, !wr_f, wr_f, exp_be, exp_wd, !resp})
        begin fails++; $display("FAIL access: got addr=%h rd=%b wr=%b be=%b wd=%h stall=%b want addr=%h rd=%b wr=%b be=%b wd=%h stall=%b",
          addr_o, rd_o, wr_o, be_o, wdata_o, stall_o, exp_addr, !wr_f, wr_f, exp_be, exp_wd, !resp); end
      if (resp) begin
        tests++;
        if (load_o !== exp_ld) begin fails++; $display("FAIL load_data: got %h want %h", load_o, exp_ld); end
      end
    end
    total_stall += 1 + (ind_f ? d1 + 1 : 0) + d2;
  endtask

  task automatic test_directed();
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h3001, 16'h0000, 16'h0000, 16'hBEEF, 0, 3, 1'b0);
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 16'h4003, 16'h12A5, 16'h0000, 16'h0000, 0, 0, 1'b0);
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h5000, 16'h0000, 16'h6001, 16'h00C3, 1, 0, 1'b0);
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 16'h5000, 16'h0000, 16'h6001, 16'h00C3, 0, 2, 1'b1);
    run_op(1'b0, 1'b1, 1'b1, 1'b0, 16'h5001, 16'h9876, 16'h7003, 16'h0000, 2, 1, 1'b0);
  endtask

  task automatic test_non_memop();
    @(posedge clk); #1;
    init = 1'b1; mem_sig = '{mem_read: 1'b0, mem_write: 1'b0, mem_indirect: 1'b1, mem_byte: 1'b1};
    resp = 1'b0; mar = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if ({rd_o, wr_o, stall_o} !== 3'b000)
        begin fails++; $display("FAIL non_memop: got rd=%b wr=%b stall=%b want 0 0 0", rd_o, wr_o, stall_o); end
      @(posedge clk); #1;
      // A stray response while idle must not disturb anything.
      resp = (k == 1);
      init = (k != 0);
      mem_sig.mem_read = (k == 0);
    end
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h2221, 16'h0000, 16'h0000, 16'h5A3C, 0, 1, 1'b0);
  endtask

  task automatic test_reset_in_ind();
    @(posedge clk); #1;
    init = 1'b1; mem_sig = '{mem_read: 1'b1, mem_write: 1'b0, mem_indirect: 1'b1, mem_byte: 1'b0};
    mar = 16'h7777; resp = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({addr_o, rd_o, stall_o} !== {16'h7776, 1'b1, 1'b1})
      begin fails++; $display("FAIL ind_before_reset: got addr=%h rd=%b stall=%b want 7776 1 1", addr_o, rd_o, stall_o); end
    #1 reset_n = 1'b0;
    #1;
    tests++;
    if ({addr_o, rd_o, wr_o, be_o, wdata_o, stall_o, load_o, cnt_o, cnt4} !== '0)
      begin fails++; $display("FAIL reset_in_ind: got addr=%h rd=%b wr=%b be=%b wd=%h stall=%b ld=%h cnt=%h want all zero",
        addr_o, rd_o, wr_o, be_o, wdata_o, stall_o, load_o, cnt_o); end
    resp = 1'b1; rdata = 16'hDEAD;
    @(posedge clk); #1;
    init = 1'b0; mem_sig = '0;
    #1 reset_n = 1'b1;
    total_stall = 0;
    @(posedge clk); #1;
    resp = 1'b1;
    #1;
    tests++;
    if ({rd_o, wr_o, stall_o, cnt_o} !== '0)
      begin fails++; $display("FAIL after_reset_idle: got rd=%b wr=%b stall=%b cnt=%h want 0", rd_o, wr_o, stall_o, cnt_o); end
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0102, 16'h0000, 16'h0000, 16'h1357, 0, 0, 1'b0);
  endtask

  task automatic test_saturation();
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000, 16'h0000, 16'h4242, 0, 19, 1'b0);
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h0802, 16'hCAFE, 16'h0000, 16'h0000, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back_random();
    for (int n = 0; n < 40; n++) begin
      int sel;
      bit rd_f, wr_f;
      sel  = $urandom_range(0, 3);
      rd_f = (sel != 1);
      wr_f = (sel == 1) || (sel == 2);
      run_op(rd_f, wr_f, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end
    @(posedge clk); #1;
    init = 1'b0; resp = 1'b0;
    #1;
    tests++;
    if (cnt_o !== 16'((total_stall > 65535) ? 65535 : total_stall))
      begin fails++; $display("FAIL final_stall_count: got %0d want %0d", cnt_o, total_stall); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_non_memop();
    test_reset_in_ind();
    test_saturation();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
